// File: rtl/conv_mac_acc.sv
// KxK convolution MAC with cross-channel accumulation and rounded/saturating requantization.
// Optional RELU_EN: clamp negative requantized results to zero.

module conv_mac_tap #(
    parameter int IMG_W = 8,
    parameter int WGT_W = 4
) (
    input  logic [IMG_W-1:0]               pix_i,
    input  logic [IMG_W-1:0]               zero_i,
    input  logic [WGT_W-1:0]               wgt_i,
    input  logic                           signed_i,
    output logic signed [IMG_W+WGT_W+1:0]  prod_o
);
    localparam int PW = IMG_W + WGT_W + 2;
    logic signed [IMG_W:0] d;
    logic signed [PW-1:0]  de, we;

    assign d  = $signed({1'b0, pix_i}) - $signed({1'b0, zero_i});
    assign de = {{(PW-IMG_W-1){d[IMG_W]}}, d};
    assign we = {{(PW-WGT_W){signed_i & wgt_i[WGT_W-1]}}, wgt_i};
    assign prod_o = de * we;
endmodule

module conv_mac_acc #(
    parameter int KSIZE  = 3,
    parameter int IMG_W  = 8,
    parameter int WGT_W  = 4,
    parameter int OUT_W  = 16,
    parameter int ACC_W  = 32,
    parameter int CH_MAX = 16,
    parameter int Q_W    = 5
) (
    input  logic                           clk,
    input  logic                           i_rst,
    input  logic                           i_inhibit,
    input  logic                           i_valid,
    input  logic                           i_last,
    input  logic                           i_signed_wgt,
    input  logic [IMG_W-1:0]               i_zero_img,
    input  logic [Q_W-1:0]                 i_q,
    input  logic [KSIZE*KSIZE*IMG_W-1:0]   i_im,
    input  logic [KSIZE*KSIZE*WGT_W-1:0]   i_ker,
    output logic                           o_valid,
    output logic [OUT_W-1:0]               o_conv,
    output logic                           o_sat,
    output logic                           o_err
);
    localparam int T  = KSIZE * KSIZE;
    localparam int PW = IMG_W + WGT_W + 2;
    localparam int CW = $clog2(CH_MAX + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]   OMAX    = (ACC_W+1)'(2**(OUT_W-1) - 1);
    localparam logic signed [ACC_W:0]   OMIN    = -OMAX - 1;

    logic                   en;
    logic [3:0]             vld_q;   // stage valids: S1 products, S2 sum, S3 result, S4 output
    logic [T-1:0][PW-1:0]   prod_d, prod_q;
    logic                   last1_q, last2_q;
    logic [Q_W-1:0]         q1_q, q2_q, res_sh_q;
    logic signed [ACC_W-1:0] sum_d, sum_q, acc_q, acc_next, res_q;
    logic signed [ACC_W:0]  acc_wide;
    logic                   acc_ovf, sticky_q, hit, close;
    logic [CW-1:0]          cnt_q, cnt_next;
    logic                   res_sat_q, res_err_q;
    logic [OUT_W-1:0]       o_conv_q;
    logic                   o_sat_q, o_err_q;

    assign en = ~i_inhibit;

    for (genvar t = 0; t < T; t++) begin : g_tap
        conv_mac_tap #(.IMG_W(IMG_W), .WGT_W(WGT_W)) u_tap (
            .pix_i    (i_im[t*IMG_W +: IMG_W]),
            .zero_i   (i_zero_img),
            .wgt_i    (i_ker[t*WGT_W +: WGT_W]),
            .signed_i (i_signed_wgt),
            .prod_o   (prod_d[t])
        );
    end

    always_comb begin
        sum_d = '0;
        for (int t = 0; t < T; t++) sum_d = sum_d + ACC_W'($signed(prod_q[t]));
    end

    // Accumulate one bit wider so overflow is visible, then pin to the signed limits.
    assign acc_wide = {acc_q[ACC_W-1], acc_q} + {sum_q[ACC_W-1], sum_q};
    assign acc_ovf  = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
    assign acc_next = acc_ovf ? (acc_wide[ACC_W] ? ACC_MIN : ACC_MAX) : acc_wide[ACC_W-1:0];
    assign cnt_next = cnt_q + CW'(1);
    assign hit      = (cnt_next == CW'(CH_MAX));
    assign close    = vld_q[1] & (last2_q | hit);

    logic [Q_W-1:0]        sh;
    logic signed [ACC_W:0] rnd, rq_wide, shifted;
    logic                  clamp_hi, clamp_lo;
    logic [OUT_W-1:0]      rq_out;

    always_comb begin
        sh = res_sh_q;
        if (int'(res_sh_q) > ACC_W - 1) sh = Q_W'(ACC_W - 1);
        rnd      = (sh == '0) ? '0 : ((ACC_W+1)'(1) << (sh - Q_W'(1)));
        rq_wide  = {res_q[ACC_W-1], res_q} + rnd;
        shifted  = rq_wide >>> sh;
        clamp_hi = shifted > OMAX;
        clamp_lo = shifted < OMIN;
        rq_out   = clamp_hi ? OMAX[OUT_W-1:0] : (clamp_lo ? OMIN[OUT_W-1:0] : shifted[OUT_W-1:0]);
`ifdef RELU_EN
        if (rq_out[OUT_W-1]) rq_out = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            vld_q     <= '0;
            prod_q    <= '0;
            last1_q   <= 1'b0;
            last2_q   <= 1'b0;
            q1_q      <= '0;
            q2_q      <= '0;
            sum_q     <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sticky_q  <= 1'b0;
            res_q     <= '0;
            res_sh_q  <= '0;
            res_sat_q <= 1'b0;
            res_err_q <= 1'b0;
            o_conv_q  <= '0;
            o_sat_q   <= 1'b0;
            o_err_q   <= 1'b0;
        end else if (en) begin
            vld_q   <= {vld_q[2], close, vld_q[0], i_valid};
            prod_q  <= prod_d;
            last1_q <= i_last;
            q1_q    <= i_q;
            sum_q   <= sum_d;
            last2_q <= last1_q;
            q2_q    <= q1_q;
            if (vld_q[1]) begin
                if (close) begin
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    sticky_q  <= 1'b0;
                    res_q     <= acc_next;
                    res_sh_q  <= q2_q;
                    res_sat_q <= sticky_q | acc_ovf;
                    res_err_q <= ~last2_q;
                end else begin
                    acc_q    <= acc_next;
                    cnt_q    <= cnt_next;
                    sticky_q <= sticky_q | acc_ovf;
                end
            end
            if (vld_q[2]) begin
                o_conv_q <= rq_out;
                o_sat_q  <= res_sat_q | clamp_hi | clamp_lo;
                o_err_q  <= res_err_q;
            end
        end
    end

    assign o_valid = vld_q[3] & en;
    assign o_conv  = o_conv_q;
    assign o_sat   = o_sat_q;
    assign o_err   = o_err_q;
endmodule
